// File: rtl/cluster_pwr_seq_pkg.sv
// rtl/cluster_pwr_seq_pkg.sv - state encoding and default delays for the cluster power sequencer
package cluster_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_CLK_ON  = 3'd2,
    ST_RST_REL = 3'd3,
    ST_ON      = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_RST_ASS = 3'd6,
    ST_PWR_DN  = 3'd7
  } state_e;

  localparam int unsigned PWR_DLY_DEF   = 16;
  localparam int unsigned CLK_DLY_DEF   = 8;
  localparam int unsigned RST_DLY_DEF   = 4;
  localparam int unsigned TO_CYCLES_DEF = 1024;
  localparam int unsigned CNT_W_DEF     = 11;

endpackage

// File: rtl/cluster_pwr_seq_if.sv
// rtl/cluster_pwr_seq_if.sv - request/status interface between SoC control registers and the sequencer
interface cluster_pwr_seq_if;

  logic        pwr_on_req;
  logic        pwr_off_req;
  logic [63:0] boot_addr;
  logic        req_rdy;
  logic        done;
  logic        err;
  logic [2:0]  state;

  modport master (
    output pwr_on_req, pwr_off_req, boot_addr,
    input  req_rdy, done, err, state
  );

  modport slave (
    input  pwr_on_req, pwr_off_req, boot_addr,
    output req_rdy, done, err, state
  );

endinterface

// File: rtl/cluster_pwr_dly_cnt.sv
// rtl/cluster_pwr_dly_cnt.sv - loadable down-counter that parks at zero
module cluster_pwr_dly_cnt #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/cluster_pwr_seq.sv
// rtl/cluster_pwr_seq.sv - power-up/power-down sequencer for the cluster (pow, clk, rstn, fetch)
// Optional DRAIN busy-wait timeout enabled by CLUSTER_PWR_SEQ_TIMEOUT_EN.
module cluster_pwr_seq
  import cluster_pwr_seq_pkg::*;
#(
  parameter int unsigned PWR_DLY   = PWR_DLY_DEF,
  parameter int unsigned CLK_DLY   = CLK_DLY_DEF,
  parameter int unsigned RST_DLY   = RST_DLY_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  cluster_pwr_seq_if.slave        req_if,
  input  logic                    cluster_busy_i,
  output logic                    cluster_pow_o,
  output logic                    cluster_byp_o,
  output logic                    cluster_clk_en_o,
  output logic                    cluster_rstn_o,
  output logic                    cluster_fetch_enable_o,
  output logic [63:0]             cluster_boot_addr_o
);

  localparam logic [CNT_W-1:0] L_PWR_DLY = CNT_W'(PWR_DLY);
  localparam logic [CNT_W-1:0] L_CLK_DLY = CNT_W'(CLK_DLY);
  localparam logic [CNT_W-1:0] L_RST_DLY = CNT_W'(RST_DLY);

  state_e           r_state;
  logic             r_pow;
  logic             r_byp;
  logic             r_clk_en;
  logic             r_rstn;
  logic             r_fetch;
  logic             r_done;
  logic [63:0]      r_boot;

  state_e           w_state_nxt;
  logic             w_pow_nxt;
  logic             w_clk_en_nxt;
  logic             w_rstn_nxt;
  logic             w_fetch_nxt;
  logic             w_done_nxt;
  logic [63:0]      w_boot_nxt;
  logic             w_go_down;
  logic             w_dly_load;
  logic [CNT_W-1:0] w_dly_val;
  logic             w_dly_zero;

  // One counter serves every delay state; it is reloaded on each state entry.
  cluster_pwr_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_dly_load),
    .val_i  (w_dly_val),
    .zero_o (w_dly_zero)
  );

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] L_TO_VAL = CNT_W'(TO_CYCLES - 1);

  logic r_err;
  logic w_to_load;
  logic w_to_zero;

  cluster_pwr_dly_cnt #(.CNT_W(CNT_W)) u_to_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_to_load),
    .val_i  (L_TO_VAL),
    .zero_o (w_to_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_OFF) && req_if.pwr_on_req) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_DRAIN) && cluster_busy_i && w_to_zero) begin
      r_err <= 1'b1;
    end
  end

  assign req_if.err = r_err;
`else
  assign req_if.err = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_pow_nxt    = r_pow;
    w_clk_en_nxt = r_clk_en;
    w_rstn_nxt   = r_rstn;
    w_fetch_nxt  = r_fetch;
    w_done_nxt   = 1'b0;
    w_boot_nxt   = r_boot;
    w_go_down    = 1'b0;
    w_dly_load   = 1'b0;
    w_dly_val    = '0;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
    w_to_load    = 1'b0;
`endif
    case (r_state)
      ST_OFF: begin
        if (req_if.pwr_on_req) begin
          w_state_nxt = ST_PWR_UP;
          w_pow_nxt   = 1'b1;
          w_boot_nxt  = req_if.boot_addr;
          w_dly_load  = 1'b1;
          w_dly_val   = L_PWR_DLY;
        end
      end
      ST_PWR_UP: begin
        if (w_dly_zero) begin
          w_state_nxt  = ST_CLK_ON;
          w_clk_en_nxt = 1'b1;
          w_dly_load   = 1'b1;
          w_dly_val    = L_CLK_DLY;
        end
      end
      ST_CLK_ON: begin
        if (w_dly_zero) begin
          w_state_nxt = ST_RST_REL;
          w_rstn_nxt  = 1'b1;
          w_dly_load  = 1'b1;
          w_dly_val   = L_RST_DLY;
        end
      end
      ST_RST_REL: begin
        if (w_dly_zero) begin
          w_state_nxt = ST_ON;
          w_fetch_nxt = 1'b1;
          w_done_nxt  = 1'b1;
        end
      end
      ST_ON: begin
        if (req_if.pwr_off_req) begin
          w_state_nxt = ST_DRAIN;
          w_fetch_nxt = 1'b0;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
          w_to_load   = 1'b1;
`endif
        end
      end
      ST_DRAIN: begin
        if (!cluster_busy_i) begin
          w_go_down = 1'b1;
        end
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
        else if (w_to_zero) begin
          w_go_down = 1'b1;
        end
`endif
        if (w_go_down) begin
          w_state_nxt = ST_RST_ASS;
          w_rstn_nxt  = 1'b0;
          w_dly_load  = 1'b1;
          w_dly_val   = L_CLK_DLY;
        end
      end
      ST_RST_ASS: begin
        if (w_dly_zero) begin
          w_state_nxt  = ST_PWR_DN;
          w_clk_en_nxt = 1'b0;
          w_dly_load   = 1'b1;
          w_dly_val    = L_PWR_DLY;
        end
      end
      ST_PWR_DN: begin
        if (w_dly_zero) begin
          w_state_nxt = ST_OFF;
          w_pow_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_OFF;
      r_pow    <= 1'b0;
      r_byp    <= 1'b0;
      r_clk_en <= 1'b0;
      r_rstn   <= 1'b0;
      r_fetch  <= 1'b0;
      r_done   <= 1'b0;
      r_boot   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pow    <= w_pow_nxt;
      r_byp    <= w_clk_en_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_rstn   <= w_rstn_nxt;
      r_fetch  <= w_fetch_nxt;
      r_done   <= w_done_nxt;
      r_boot   <= w_boot_nxt;
    end
  end

  assign req_if.req_rdy         = (r_state == ST_OFF) || (r_state == ST_ON);
  assign req_if.done            = r_done;
  assign req_if.state           = r_state;
  assign cluster_pow_o          = r_pow;
  assign cluster_byp_o          = r_byp;
  assign cluster_clk_en_o       = r_clk_en;
  assign cluster_rstn_o         = r_rstn;
  assign cluster_fetch_enable_o = r_fetch;
  assign cluster_boot_addr_o    = r_boot;

endmodule
